ppi_bus_arbiter: RTL and testbench

PPI_BUS_ARBITER -- requirements
Module: ppi_bus_arbiter

---
 rtl/ppi_bus_arbiter.sv | 131 +++++++++++++
 tb/tb_ppi_bus_arbiter.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ppi_bus_arbiter.sv
// ppi_bus_arbiter
//   Shares one 8255-style PPI register port between two requesters. A
//   transaction is captured in IDLE, presented for one SETUP cycle, optionally
//   strobed (ppi_we_n low for STROBE_CYCLES cycles), and acknowledged in DONE
//   with a one-cycle ackN pulse to the requester that owned the port.
//
//   Configuration macro: PPI_ARB_RR_EN
//     undefined : fixed priority, requester 0 wins a tie.
//     defined   : round-robin, the requester not served last wins a tie.
//
//   Ports
//     clk_sys, reset          : clock, synchronous active-high reset
//     reqN/addrN/wrN/wdataN   : requester N transaction (held until ackN)
//     ackN                    : one-cycle completion pulse to requester N
//     rdataN                  : requester N read data, registered
//     ppi_addr/ppi_idata      : address and write data to the PPI
//     ppi_we_n                : PPI write strobe, active low, registered
//     ppi_odata               : combinational read data from the PPI
//     busy/grant              : transaction in flight / owning requester
module ppi_bus_arbiter #(
    parameter int unsigned STROBE_CYCLES = 1
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       req0,
    input  logic [1:0] addr0,
    input  logic       wr0,
    input  logic [7:0] wdata0,
    input  logic       req1,
    input  logic [1:0] addr1,
    input  logic       wr1,
    input  logic [7:0] wdata1,
    output logic       ack0,
    output logic       ack1,
    output logic [7:0] rdata0,
    output logic [7:0] rdata1,
    output logic [1:0] ppi_addr,
    output logic       ppi_we_n,
    output logic [7:0] ppi_idata,
    input  logic [7:0] ppi_odata,
    output logic       busy,
    output logic       grant
);

    typedef enum logic [1:0] {IDLE, SETUP, STROBE, DONE} state_t;

    localparam logic [3:0] STROBE_LAST = 4'(STROBE_CYCLES - 1);

    state_t     state, state_next;
    logic [3:0] strb_cnt, strb_cnt_next;
    logic       wr_q;
    logic       any_req;
    logic       win;

    assign any_req = req0 | req1;

`ifdef PPI_ARB_RR_EN
    // Index of the requester granted most recently; a tie goes to the other one.
    logic last_served;
    assign win = (req0 & req1) ? ~last_served : ~req0;
`else
    assign win = ~req0;
`endif

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no branch can leave one unassigned and infer a latch.
        state_next    = state;
        strb_cnt_next = '0;
        busy          = 1'b1;
        ack0          = 1'b0;
        ack1          = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (any_req) state_next = SETUP;
            end
            SETUP: state_next = wr_q ? STROBE : DONE;
            STROBE: begin
                if (strb_cnt == STROBE_LAST) state_next = DONE;
                else strb_cnt_next = strb_cnt + 4'd1;
            end
            DONE: begin
                ack0       = ~grant;
                ack1       = grant;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            // NOTE: rdata is host-visible state and is cleared on reset along with the control registers.
            state     <= IDLE;
            strb_cnt  <= '0;
            ppi_we_n  <= 1'b1;
            ppi_addr  <= '0;
            ppi_idata <= '0;
            grant     <= 1'b0;
            wr_q      <= 1'b0;
            rdata0    <= '0;
            rdata1    <= '0;
`ifdef PPI_ARB_RR_EN
            last_served <= 1'b1;
`endif
        end else begin
            // NOTE: non-blocking assignments so every register here updates from the same pre-edge values.
            state    <= state_next;
            strb_cnt <= strb_cnt_next;
            // Strobe is registered off the next state so the PPI sees a clean edge.
            ppi_we_n <= (state_next != STROBE);

            // Requester inputs are captured only here; later changes are ignored.
            if (state == IDLE && any_req) begin
                grant     <= win;
                ppi_addr  <= win ? addr1  : addr0;
                ppi_idata <= win ? wdata1 : wdata0;
                wr_q      <= win ? wr1    : wr0;
`ifdef PPI_ARB_RR_EN
                last_served <= win;
`endif
            end

            if (state == SETUP && !wr_q) begin
                if (grant) rdata1 <= ppi_odata;
                else       rdata0 <= ppi_odata;
            end
        end
    end

endmodule

// File: tb/tb_ppi_bus_arbiter.sv
`timescale 1ns/1ps
module tb_ppi_bus_arbiter;

    localparam int S  = 1;
    localparam int S4 = 4;

    logic clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    // ---------------- main DUT (STROBE_CYCLES = 1) ----------------
    logic       reset;
    logic       req0, req1, wr0, wr1;
    logic [1:0] addr0, addr1;
    logic [7:0] wdata0, wdata1;
    logic       ack0, ack1, ppi_we_n, busy, grant;
    logic [7:0] rdata0, rdata1, ppi_idata, ppi_odata;
    logic [1:0] ppi_addr;

    // PPI register file: latches on the falling edge of the write strobe.
    logic [7:0] ppi_regs [4] = '{8'h11, 8'h5A, 8'h33, 8'h44};
    always @(negedge ppi_we_n) ppi_regs[ppi_addr] <= ppi_idata;
    assign ppi_odata = ppi_regs[ppi_addr];

    ppi_bus_arbiter #(.STROBE_CYCLES(S)) dut (
        .clk_sys(clk_sys), .reset(reset),
        .req0(req0), .addr0(addr0), .wr0(wr0), .wdata0(wdata0),
        .req1(req1), .addr1(addr1), .wr1(wr1), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
        .ppi_addr(ppi_addr), .ppi_we_n(ppi_we_n), .ppi_idata(ppi_idata),
        .ppi_odata(ppi_odata), .busy(busy), .grant(grant)
    );

    // ---------------- second DUT (STROBE_CYCLES = 4) ----------------
    logic       b_reset, b_req0, b_wr0;
    logic [1:0] b_addr0, b_paddr;
    logic [7:0] b_wdata0, b_odata, b_rdata0, b_rdata1, b_idata;
    logic       b_ack0, b_ack1, b_we_n, b_busy, b_grant;
    assign b_odata = 8'hA5;

    ppi_bus_arbiter #(.STROBE_CYCLES(S4)) dut_s4 (
        .clk_sys(clk_sys), .reset(b_reset),
        .req0(b_req0), .addr0(b_addr0), .wr0(b_wr0), .wdata0(b_wdata0),
        .req1(1'b0), .addr1(2'd0), .wr1(1'b0), .wdata1(8'd0),
        .ack0(b_ack0), .ack1(b_ack1), .rdata0(b_rdata0), .rdata1(b_rdata1),
        .ppi_addr(b_paddr), .ppi_we_n(b_we_n), .ppi_idata(b_idata),
        .ppi_odata(b_odata), .busy(b_busy), .grant(b_grant)
    );

    // ---------------- checking ----------------
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model + scoreboard ----------------
    typedef struct {
        bit         who;
        logic [1:0] addr;
        bit         wr;
        logic [7:0] wdata;
        logic [7:0] rdata;
        int         ack_at;
    } txn_t;

    txn_t       exp_q[$];
    int         cyc = 0;
    int         m_free_at = 0;
    bit         m_rst = 1'b1;
    logic [7:0] m_regs [4] = '{8'h11, 8'h5A, 8'h33, 8'h44};
`ifdef PPI_ARB_RR_EN
    bit         m_last = 1'b1;
`endif

    // Transaction-level model: the port is a single server; when it is free
    // and someone is requesting, the winner's request is taken and finishes a
    // fixed number of cycles later. Writes take S strobe cycles extra.
    initial begin
        bit   m_who;
        txn_t m_t;
        forever begin
            @(posedge clk_sys);
            cyc++;
            m_rst = reset;
            if (reset) begin
                exp_q.delete();
                m_free_at = cyc + 1;
`ifdef PPI_ARB_RR_EN
                m_last = 1'b1;
`endif
            end else if (cyc >= m_free_at && (req0 || req1)) begin
                if (req0 && req1) begin
`ifdef PPI_ARB_RR_EN
                    m_who = (m_last == 1'b1) ? 1'b0 : 1'b1;
`else
                    m_who = 1'b0;
`endif
                end else begin
                    m_who = req1;
                end
                m_t.who    = m_who;
                m_t.addr   = m_who ? addr1 : addr0;
                m_t.wr     = m_who ? wr1 : wr0;
                m_t.wdata  = m_who ? wdata1 : wdata0;
                m_t.rdata  = m_regs[m_t.addr];
                m_t.ack_at = cyc + 2 + (m_t.wr ? S : 0);
                if (m_t.wr) m_regs[m_t.addr] = m_t.wdata;
                m_free_at = m_t.ack_at + 1;
`ifdef PPI_ARB_RR_EN
                m_last = m_who;
`endif
                exp_q.push_back(m_t);
            end
        end
    end

    // Monitor: compares DUT outputs against the in-flight expected transaction.
    initial begin
        txn_t t;
        int   low_len  = 0;
        int   high_len = 0;
        bit   seen_strobe = 1'b0;
        forever begin
            @(negedge clk_sys);
            if (m_rst) begin
                low_len = 0; high_len = 0; seen_strobe = 1'b0;
            end else begin
                check("busy", busy, exp_q.size() != 0);
                if (exp_q.size() != 0) check("grant", grant, exp_q[0].who);
                check("ack_onehot", ack0 & ack1, 0);

                if (!ppi_we_n) begin
                    if (exp_q.size() != 0) begin
                        check("strobe_is_write", exp_q[0].wr, 1);
                        check("strobe_addr", ppi_addr, exp_q[0].addr);
                        check("strobe_data", ppi_idata, exp_q[0].wdata);
                    end else begin
                        check("we_n_idle", ppi_we_n, 1);
                    end
                    if (low_len == 0 && seen_strobe) check("strobe_gap_ge3", high_len >= 3, 1);
                    seen_strobe = 1'b1;
                    low_len++;
                    high_len = 0;
                end else begin
                    if (low_len != 0) check("strobe_len", low_len, S);
                    low_len = 0;
                    high_len++;
                end

                if (ack0 || ack1) begin
                    if (exp_q.size() == 0) begin
                        check("ack_unexpected", ack0 | ack1, 0);
                    end else begin
                        t = exp_q.pop_front();
                        check("ack_who", ack1, t.who);
                        check("ack_cycle", cyc + 1, t.ack_at);
                        check("done_addr", ppi_addr, t.addr);
                        if (t.wr) check("done_wdata", ppi_idata, t.wdata);
                        else      check("rdata", t.who ? rdata1 : rdata0, t.rdata);
                    end
                end else if (exp_q.size() != 0 && exp_q[0].ack_at <= cyc + 1) begin
                    check("ack_present", ack0 | ack1, 1);
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic wait_ack(input bit who, input int budget, output int n);
        n = 0;
        do begin
            @(negedge clk_sys);
            n++;
        end while (!(who ? ack1 : ack0) && n < budget);
        check(who ? "ack1_seen" : "ack0_seen", who ? ack1 : ack0, 1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int         n, n0, n1, k, lows;
        logic [5:0] ord;
        reset = 1'b1; req0 = 1'b0; req1 = 1'b0; wr0 = 1'b0; wr1 = 1'b0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        b_reset = 1'b1; b_req0 = 1'b0; b_wr0 = 1'b0; b_addr0 = '0; b_wdata0 = '0;
        repeat (2) @(negedge clk_sys);

        // Reset state
        check("rst_we_n", ppi_we_n, 1);
        check("rst_addr", ppi_addr, 0);
        check("rst_idata", ppi_idata, 0);
        check("rst_acks", {ack1, ack0}, 0);
        check("rst_rdata", {rdata1, rdata0}, 0);
        check("rst_busy", busy, 0);
        check("rst_grant", grant, 0);
        reset = 1'b0; b_reset = 1'b0;

        // Single write: ppi_we_n low only at T+2, ack0 at T+3
        req0 = 1'b1; wr0 = 1'b1; addr0 = 2'd3; wdata0 = 8'h82;
        @(negedge clk_sys); check("w_setup_we_n", ppi_we_n, 1);
        @(negedge clk_sys); check("w_strobe_we_n", ppi_we_n, 0);
        check("w_addr", ppi_addr, 3); check("w_idata", ppi_idata, 8'h82);
        @(negedge clk_sys); check("w_ack0", ack0, 1); check("w_done_we_n", ppi_we_n, 1);
        req0 = 1'b0;
        @(negedge clk_sys);

        // Single read: ack1 at T+2 with rdata1 = 0x5A
        req1 = 1'b1; wr1 = 1'b0; addr1 = 2'd1;
        @(negedge clk_sys); check("r_setup_we_n", ppi_we_n, 1);
        @(negedge clk_sys); check("r_ack1", ack1, 1); check("r_rdata1", rdata1, 8'h5A);
        check("r_done_we_n", ppi_we_n, 1);
        req1 = 1'b0;
        @(negedge clk_sys);

        // Contention: both keep requesting back-to-back writes, three each
        n0 = 0; n1 = 0; k = 0; ord = '0;
        req0 = 1'b1; wr0 = 1'b1; addr0 = 2'd0; wdata0 = 8'hA0;
        req1 = 1'b1; wr1 = 1'b1; addr1 = 2'd2; wdata1 = 8'hB0;
        for (int c = 0; c < 80 && (n0 < 3 || n1 < 3); c++) begin
            @(negedge clk_sys);
            if (ack0 || ack1) begin
                if (k < 6) ord[k] = ack1;
                k++;
            end
            if (ack0) begin
                n0++;
                if (n0 < 3) begin addr0 = 2'(n0); wdata0 = 8'hA0 + 8'(n0); end
                else req0 = 1'b0;
            end
            if (ack1) begin
                n1++;
                if (n1 < 3) begin addr1 = 2'(n1 + 1); wdata1 = 8'hB0 + 8'(n1); end
                else req1 = 1'b0;
            end
        end
        check("cont_counts", {n0[7:0], n1[7:0]}, {8'd3, 8'd3});
`ifdef PPI_ARB_RR_EN
        check("cont_order_rr", ord, 6'b101010);
`else
        check("cont_order_fixed", ord, 6'b111000);
`endif
        @(negedge clk_sys);

        // Withdrawal and stability: req0 dropped in SETUP, wdata0 cleared in STROBE
        req0 = 1'b1; wr0 = 1'b1; addr0 = 2'd2; wdata0 = 8'hC3;
        @(negedge clk_sys); req0 = 1'b0;
        @(negedge clk_sys); wdata0 = 8'h00; check("wd_strobe_idata", ppi_idata, 8'hC3);
        @(negedge clk_sys); check("wd_ack0", ack0, 1); check("wd_done_idata", ppi_idata, 8'hC3);
        req1 = 1'b1; wr1 = 1'b0; addr1 = 2'd2;
        wait_ack(1'b1, 10, n);
        check("wd_readback", rdata1, 8'hC3);
        req1 = 1'b0;
        @(negedge clk_sys);

        // STROBE_CYCLES = 4 instance: read latency, write latency, abort
        b_req0 = 1'b1; b_wr0 = 1'b0; b_addr0 = 2'd1;
        n = 0;
        do begin @(negedge clk_sys); n++; end while (!b_ack0 && n < 12);
        check("s4_read_lat", n, 2);
        check("s4_rdata0", b_rdata0, 8'hA5);
        b_req0 = 1'b0;
        @(negedge clk_sys);
        b_req0 = 1'b1; b_wr0 = 1'b1; b_addr0 = 2'd2; b_wdata0 = 8'h3C;
        n = 0; lows = 0;
        do begin
            @(negedge clk_sys); n++;
            if (!b_we_n) lows++;
        end while (!b_ack0 && n < 16);
        check("s4_write_lat", n, 2 + S4);
        check("s4_low_cycles", lows, S4);
        b_req0 = 1'b0;
        @(negedge clk_sys);
        b_req0 = 1'b1; b_wr0 = 1'b1; b_addr0 = 2'd3; b_wdata0 = 8'h77;
        @(negedge clk_sys);
        @(negedge clk_sys); check("ab_strobe", b_we_n, 0);
        @(negedge clk_sys); b_reset = 1'b1;
        @(negedge clk_sys);
        check("ab_we_n", b_we_n, 1);
        check("ab_busy", b_busy, 0);
        check("ab_addr", b_paddr, 0);
        check("ab_idata", b_idata, 0);
        check("ab_rdata", {b_rdata1, b_rdata0}, 0);
        check("ab_grant", b_grant, 0);
        b_reset = 1'b0; b_req0 = 1'b0;
        n = 0; lows = 0;
        repeat (10) begin
            @(negedge clk_sys);
            if (b_ack0 || b_ack1) n++;
            if (!b_we_n) lows++;
        end
        check("ab_no_ack", n, 0);
        check("ab_no_strobe", lows, 0);

        // Randomized traffic on the main DUT
        for (int c = 0; c < 600; c++) begin
            @(negedge clk_sys);
            if (ack0) req0 = 1'b0;
            else if (!req0 && $urandom_range(0, 2) == 0) begin
                req0 = 1'b1; wr0 = 1'($urandom_range(0, 1));
                addr0 = 2'($urandom_range(0, 3)); wdata0 = 8'($urandom);
            end
            if (ack1) req1 = 1'b0;
            else if (!req1 && $urandom_range(0, 2) == 0) begin
                req1 = 1'b1; wr1 = 1'($urandom_range(0, 1));
                addr1 = 2'($urandom_range(0, 3)); wdata1 = 8'($urandom);
            end
        end
        for (int c = 0; c < 60 && (req0 || req1); c++) begin
            @(negedge clk_sys);
            if (ack0) req0 = 1'b0;
            if (ack1) req1 = 1'b0;
        end
        check("drain_reqs_acked", {req1, req0}, 0);
        req0 = 1'b0; req1 = 1'b0;
        repeat (6) @(negedge clk_sys);
        check("queue_empty", exp_q.size(), 0);
        check("final_idle", busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
